// File: rtl/spi_reg_bank.sv
// Register bank and command decoder fed by the SPI byte receiver.
// Each chip-select frame is one command byte followed by auto-incrementing data bytes.
module spi_reg_bank #(
   parameter int unsigned NUM_REGS  = 16,
   parameter logic [7:0]  RESET_VAL = 8'h00,
   parameter logic [7:0]  ID_BYTE   = 8'hA5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cs_ni,
   input  logic [7:0]            rx_data_i,
   input  logic                  rx_stb_i,
   output logic [7:0]            tx_data_o,
   output logic [8*NUM_REGS-1:0] regs_o,
   output logic                  wr_stb_o,
   output logic [6:0]            wr_addr_o,
   output logic [7:0]            wr_data_o,
   output logic                  busy_o
);

   localparam int unsigned AW = 7;
   localparam int unsigned DW = 8;

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

   state_e                     state_q;
   logic [NUM_REGS-1:0][DW-1:0] regs_q;
   logic [AW-1:0]              addr_q;
   logic [AW-1:0]              addr_d;
   logic                       wr_mode_q;
   logic [DW-1:0]              tx_q;
   logic                       wr_stb_q;
   logic [AW-1:0]              wr_addr_q;
   logic [DW-1:0]              wr_data_q;
   logic                       busy_q;
   logic                       in_range_c;
   logic                       wr_hit_c;
   logic [DW-1:0]              cmd_rd_c;
   logic [DW-1:0]              nxt_rd_c;

   // Address walk: wrap at the top of the bank, otherwise plain 7-bit increment.
   always_comb begin
      addr_d     = (32'(addr_q) == NUM_REGS - 1) ? '0 : addr_q + AW'(1);
      in_range_c = 32'(addr_q) < NUM_REGS;
      wr_hit_c   = (state_q == DATA) && rx_stb_i && wr_mode_q && in_range_c;
   end

   // Read muxes; addresses beyond the bank match nothing and read as zero.
   always_comb begin
      cmd_rd_c = '0;
      nxt_rd_c = '0;
      for (int unsigned n = 0; n < NUM_REGS; n++) begin
         if (rx_data_i[AW-1:0] == AW'(n)) cmd_rd_c = regs_q[n];
         if (addr_d == AW'(n))            nxt_rd_c = regs_q[n];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         regs_q    <= {NUM_REGS{RESET_VAL}};
         addr_q    <= '0;
         wr_mode_q <= 1'b0;
         tx_q      <= ID_BYTE;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         wr_stb_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               tx_q <= ID_BYTE;
               if (!cs_ni) begin
                  state_q <= CMD;
                  busy_q  <= 1'b1;
               end
            end
            CMD: begin
               if (rx_stb_i) begin
                  addr_q    <= rx_data_i[AW-1:0];
                  wr_mode_q <= rx_data_i[DW-1];
                  tx_q      <= cmd_rd_c;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (rx_stb_i) begin
                  addr_q <= addr_d;
                  tx_q   <= nxt_rd_c;
               end
               if (wr_hit_c) begin
                  wr_stb_q  <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= rx_data_i;
               end
               for (int unsigned n = 0; n < NUM_REGS; n++) begin
                  if (wr_hit_c && addr_q == AW'(n)) regs_q[n] <= rx_data_i;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Deselect wins over state and tx, after any same-cycle byte was applied.
         if (cs_ni) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tx_q    <= ID_BYTE;
         end
      end
   end

   assign tx_data_o = tx_q;
   assign regs_o    = regs_q;
   assign wr_stb_o  = wr_stb_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: expected writes are queued at stimulus
// time and retired by a monitor as wr_stb_o pulses appear.
module tb_spi_reg_bank;

   localparam int unsigned NR = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cs_n = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_stb = 1'b0;
   logic [7:0]    tx_data;
   logic [8*NR-1:0] regs;
   logic          wr_stb;
   logic [6:0]    wr_addr;
   logic [7:0]    wr_data;
   logic          busy;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] mdl[NR];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;

   spi_reg_bank #(.NUM_REGS(NR), .RESET_VAL(8'h00), .ID_BYTE(8'hA5)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .cs_ni     (cs_n),
      .rx_data_i (rx_data),
      .rx_stb_i  (rx_stb),
      .tx_data_o (tx_data),
      .regs_o    (regs),
      .wr_stb_o  (wr_stb),
      .wr_addr_o (wr_addr),
      .wr_data_o (wr_data),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Retire queued writes as the DUT reports them.
   always @(negedge clk) begin
      if (wr_stb === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected got addr=%0d data=%h cyc=%0d", wr_addr, wr_data, cyc);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (wr_addr !== e.addr || wr_data !== e.data || cyc !== e.cyc) begin
               failures++;
               $display("FAIL wr_txn got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                        wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stb(input logic [7:0] d);
      rx_data = d;
      rx_stb  = 1'b1;
      tick();
      rx_stb  = 1'b0;
   endtask

   task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
      exp_q.push_back('{addr: a, data: d, cyc: cyc + 1});
      mdl[a] = d;
   endtask

   task automatic test_reset();
      for (int n = 0; n < NR; n++) mdl[n] = 8'h00;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (tx_data !== 8'hA5 || busy !== 1'b0 || wr_stb !== 1'b0) begin
         failures++;
         $display("FAIL reset_out got tx=%h busy=%b stb=%b exp tx=a5 busy=0 stb=0", tx_data, busy, wr_stb);
      end
      cs_n = 1'b0;
      tick();
      stb(8'h81);
      push_wr(7'd1, 8'h55);
      stb(8'h55);
      rst = 1'b1;
      rx_data = 8'h66;
      rx_stb = 1'b1;
      tick();
      rx_stb = 1'b0;
      tick();
      rst = 1'b0;
      for (int n = 0; n < NR; n++) mdl[n] = 8'h00;
      checks++;
      if (tx_data !== 8'hA5 || busy !== 1'b0 || wr_stb !== 1'b0 || wr_addr !== 7'd0 || wr_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid got tx=%h busy=%b stb=%b addr=%0d data=%h exp a5/0/0/0/00",
                  tx_data, busy, wr_stb, wr_addr, wr_data);
      end
      for (int n = 0; n < NR; n++) begin
         checks++;
         if (regs[8*n +: 8] !== mdl[n]) begin
            failures++;
            $display("FAIL reset_reg%0d got %h exp %h", n, regs[8*n +: 8], mdl[n]);
         end
      end
      cs_n = 1'b1;
      tick();
   endtask

   task automatic test_burst_write();
      cs_n = 1'b0;
      tick();
      stb(8'h83);
      push_wr(7'd3, 8'h11);
      stb(8'h11);
      push_wr(7'd4, 8'h22);
      stb(8'h22);
      checks++;
      if (tx_data !== mdl[5] || busy !== 1'b1) begin
         failures++;
         $display("FAIL bw_tx got tx=%h busy=%b exp tx=%h busy=1", tx_data, busy, mdl[5]);
      end
      cs_n = 1'b1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL bw_busy_hold got %b exp 1", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || tx_data !== 8'hA5) begin
         failures++;
         $display("FAIL bw_end got busy=%b tx=%h exp busy=0 tx=a5", busy, tx_data);
      end
      checks++;
      if (regs[8*3 +: 8] !== 8'h11 || regs[8*4 +: 8] !== 8'h22) begin
         failures++;
         $display("FAIL bw_regs got r3=%h r4=%h exp 11 22", regs[8*3 +: 8], regs[8*4 +: 8]);
      end
   endtask

   task automatic test_burst_read();
      cs_n = 1'b0;
      tick();
      stb(8'h8F);
      push_wr(7'd15, 8'h5A);
      stb(8'h5A);
      push_wr(7'd0, 8'hC3);
      stb(8'hC3);
      cs_n = 1'b1;
      tick();
      cs_n = 1'b0;
      tick();
      checks++;
      if (tx_data !== 8'hA5 || busy !== 1'b1) begin
         failures++;
         $display("FAIL br_cmd got tx=%h busy=%b exp a5 1", tx_data, busy);
      end
      stb(8'h0F);
      checks++;
      if (tx_data !== 8'h5A) begin
         failures++;
         $display("FAIL br_after_cmd got %h exp 5a", tx_data);
      end
      stb(8'h00);
      checks++;
      if (tx_data !== 8'hC3) begin
         failures++;
         $display("FAIL br_wrap got %h exp c3", tx_data);
      end
      stb(8'h00);
      checks++;
      if (tx_data !== mdl[1]) begin
         failures++;
         $display("FAIL br_next got %h exp %h", tx_data, mdl[1]);
      end
      cs_n = 1'b1;
      tick();
      for (int n = 0; n < NR; n++) begin
         checks++;
         if (regs[8*n +: 8] !== mdl[n]) begin
            failures++;
            $display("FAIL br_reg%0d got %h exp %h", n, regs[8*n +: 8], mdl[n]);
         end
      end
   endtask

   task automatic test_out_of_range();
      cs_n = 1'b0;
      tick();
      stb(8'hFF);
      checks++;
      if (tx_data !== 8'h00) begin
         failures++;
         $display("FAIL oor_tx got %h exp 00", tx_data);
      end
      stb(8'h77);
      checks++;
      if (tx_data !== mdl[0]) begin
         failures++;
         $display("FAIL oor_wrap_tx got %h exp %h", tx_data, mdl[0]);
      end
      push_wr(7'd0, 8'h88);
      stb(8'h88);
      checks++;
      if (tx_data !== mdl[1]) begin
         failures++;
         $display("FAIL oor_next_tx got %h exp %h", tx_data, mdl[1]);
      end
      cs_n = 1'b1;
      tick();
      checks++;
      if (regs[7:0] !== 8'h88) begin
         failures++;
         $display("FAIL oor_reg0 got %h exp 88", regs[7:0]);
      end
   endtask

   task automatic test_abort();
      cs_n = 1'b0;
      tick();
      stb(8'h82);
      push_wr(7'd2, 8'h44);
      cs_n = 1'b1;
      stb(8'h44);
      checks++;
      if (busy !== 1'b0 || tx_data !== 8'hA5 || regs[8*2 +: 8] !== 8'h44) begin
         failures++;
         $display("FAIL abort got busy=%b tx=%h r2=%h exp 0 a5 44", busy, tx_data, regs[8*2 +: 8]);
      end
      cs_n = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b1 || tx_data !== 8'hA5) begin
         failures++;
         $display("FAIL abort_next_cmd got busy=%b tx=%h exp 1 a5", busy, tx_data);
      end
      stb(8'h02);
      checks++;
      if (tx_data !== 8'h44) begin
         failures++;
         $display("FAIL abort_readback got %h exp 44", tx_data);
      end
      cs_n = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      cs_n = 1'b0;
      tick();
      stb(8'h8E);
      push_wr(7'd14, 8'hE1);
      stb(8'hE1);
      push_wr(7'd15, 8'hF2);
      stb(8'hF2);
      checks++;
      if (tx_data !== mdl[0]) begin
         failures++;
         $display("FAIL b2b_tx got %h exp %h", tx_data, mdl[0]);
      end
      cs_n = 1'b1;
      tick();
      for (int n = 0; n < NR; n++) begin
         checks++;
         if (regs[8*n +: 8] !== mdl[n]) begin
            failures++;
            $display("FAIL b2b_reg%0d got %h exp %h", n, regs[8*n +: 8], mdl[n]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_burst_write();
      test_burst_read();
      test_out_of_range();
      test_abort();
      test_back_to_back();
      tick(); tick();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL wr_missing got %0d outstanding exp 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
